// File: rtl/seq_decimal_display_if.sv
// rtl/seq_decimal_display_if.sv - request/result bundle for seq_decimal_display
interface seq_decimal_display_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                start;
    logic [WIDTH-1:0]    value;
    logic                hex_mode;
    logic                blank_lz;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic                neg;
    logic                overflow;
    logic [7*DIGITS-1:0] seg;
    logic [6:0]          neg_seg;

    modport master (output start, value, hex_mode, blank_lz,
                    input  busy, done, bcd, neg, overflow, seg, neg_seg);
    modport slave  (input  start, value, hex_mode, blank_lz,
                    output busy, done, bcd, neg, overflow, seg, neg_seg);
endinterface

// File: rtl/seq_decimal_display.sv
// rtl/seq_decimal_display.sv - sequential binary to decimal/hex converter with 7-segment drive
module seq_decimal_display #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_decimal_display_if.slave io
);
    localparam int CW   = $clog2(WIDTH + 1);
    localparam int EXTW = (4 * DIGITS > WIDTH) ? 4 * DIGITS : WIDTH;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [4*DIGITS-1:0] work_q, work_d;
    logic                ovf_q, ovf_d;
    logic                neg_cap_q, neg_cap_d;
    logic                blank_cap_q, blank_cap_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                neg_q, neg_d;
    logic                overflow_q, overflow_d;
    logic [7*DIGITS-1:0] seg_q, seg_d;

    logic                neg_in;
    logic [WIDTH-1:0]    mag;
    logic [EXTW-1:0]     value_ext;
    logic [4*DIGITS-1:0] adj, step_work;
    logic [WIDTH-1:0]    step_bin;
    logic                step_carry;
    logic                load_en, src_neg, src_ovf, src_blank;
    logic [4*DIGITS-1:0] src_bcd;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Scan from the top digit; 'lead' stays set while only zeros have been seen.
    function automatic logic [7*DIGITS-1:0] format_seg(input logic [4*DIGITS-1:0] d,
                                                        input logic ovf, input logic blank);
        logic                lead;
        logic [7*DIGITS-1:0] r;
        lead = blank;
        r    = '1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (d[4*k +: 4] != 4'h0) lead = 1'b0;
            if (ovf)                 r[7*k +: 7] = SEG_DASH;
            else if (lead && k != 0) r[7*k +: 7] = SEG_BLANK;
            else                     r[7*k +: 7] = seg7(d[4*k +: 4]);
        end
        return r;
    endfunction

    assign neg_in    = (SIGNED != 0) && io.value[WIDTH-1];
    assign mag       = neg_in ? (~io.value + 1'b1) : io.value;
    assign value_ext = EXTW'(io.value);

    always_comb begin
        adj = work_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (work_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
        end
        {step_carry, step_work, step_bin} = {adj, bin_q, 1'b0};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bin_d       = bin_q;
        work_d      = work_q;
        ovf_d       = ovf_q;
        neg_cap_d   = neg_cap_q;
        blank_cap_d = blank_cap_q;
        bcd_d       = bcd_q;
        neg_d       = neg_q;
        overflow_d  = overflow_q;
        seg_d       = seg_q;
        load_en     = 1'b0;
        src_bcd     = step_work;
        src_neg     = neg_cap_q;
        src_ovf     = ovf_q | step_carry;
        src_blank   = blank_cap_q;
        case (state_q)
            IDLE: begin
                if (io.start) begin
                    blank_cap_d = io.blank_lz;
                    cnt_d       = '0;
                    work_d      = '0;
                    ovf_d       = 1'b0;
                    bin_d       = mag;
                    neg_cap_d   = neg_in;
                    if (io.hex_mode) begin
                        state_d   = LOAD;
                        load_en   = 1'b1;
                        src_bcd   = value_ext[4*DIGITS-1:0];
                        src_neg   = 1'b0;
                        src_ovf   = 1'b0;
                        src_blank = io.blank_lz;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = step_work;
                bin_d  = step_bin;
                ovf_d  = ovf_q | step_carry;
                cnt_d  = cnt_q + 1'b1;
                // Results are registered on entry to LOAD so they are visible alongside done.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = LOAD;
                    load_en = 1'b1;
                end
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (load_en) begin
            bcd_d      = src_bcd;
            neg_d      = src_neg;
            overflow_d = src_ovf;
            seg_d      = format_seg(src_bcd, src_ovf, src_blank);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bin_q       <= '0;
            work_q      <= '0;
            ovf_q       <= 1'b0;
            neg_cap_q   <= 1'b0;
            blank_cap_q <= 1'b0;
            bcd_q       <= '0;
            neg_q       <= 1'b0;
            overflow_q  <= 1'b0;
            seg_q       <= '1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            work_q      <= work_d;
            ovf_q       <= ovf_d;
            neg_cap_q   <= neg_cap_d;
            blank_cap_q <= blank_cap_d;
            bcd_q       <= bcd_d;
            neg_q       <= neg_d;
            overflow_q  <= overflow_d;
            seg_q       <= seg_d;
        end
    end

    assign io.busy     = (state_q != IDLE);
    assign io.done     = (state_q == LOAD);
    assign io.bcd      = bcd_q;
    assign io.neg      = neg_q;
    assign io.overflow = overflow_q;
    assign io.seg      = seg_q;
    assign io.neg_seg  = neg_q ? SEG_DASH : SEG_BLANK;
endmodule

// File: doc/seq_decimal_display.md
SEQ_DECIMAL_DISPLAY -- requirements
Module: seq_decimal_display

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 16, giving the input value width in bits (range 4..32).
REQ-002 The block SHALL have the parameter DIGITS, default 5, giving the number of displayed digits (range 1..10).
REQ-003 The block SHALL have the parameter SIGNED, default 1, where 1 means the value is two's complement and 0 means it is unsigned.
REQ-004 clk  input  1  the single clock; all state SHALL be updated on its rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 start  input  1  conversion request, honoured only in IDLE.
REQ-007 value  input  WIDTH  the number to convert, sampled on an accepted start.
REQ-008 hex_mode  input  1  when 1 the block shows raw hex nibbles instead of decimal; sampled on an accepted start.
REQ-009 blank_lz  input  1  when 1 the block blanks leading zeros; sampled on an accepted start.
REQ-010 busy  output  1  high while a conversion is in progress.
REQ-011 done  output  1  single-cycle pulse when the result registers update.
REQ-012 bcd  output  4*DIGITS  result digits, with digit 0 at bits [3:0].
REQ-013 neg  output  1  result is negative.
REQ-014 overflow  output  1  the magnitude does not fit in DIGITS digits.
REQ-015 seg  output  7*DIGITS  active-low segment patterns for each digit, with digit 0 at bits [6:0] and bit order g..a (bit6 = g, bit0 = a).
REQ-016 neg_seg  output  7  sign digit; 7'b0111111 when neg is 1, otherwise 7'b1111111.

Function
REQ-017 The state machine SHALL have three states: IDLE, SHIFT and LOAD; reset SHALL force IDLE.
REQ-018 In IDLE, start=1 SHALL capture value, hex_mode and blank_lz, set busy=1, and move to SHIFT if hex_mode=0 or to LOAD if hex_mode=1.
REQ-019 Capture magnitude rule:
  - if SIGNED=1 and value[WIDTH-1]=1, the captured magnitude SHALL be the WIDTH-bit unsigned value (~value)+1 and neg SHALL be set to 1 at LOAD;
  - the most-negative input (e.g. 16'h8000) SHALL yield magnitude 2^(WIDTH-1).
REQ-020 SHIFT SHALL perform exactly one shift-add-3 (double-dabble) step per cycle for WIDTH cycles and then go to LOAD.
REQ-021 A carry out of digit DIGITS-1 during any shift step SHALL set a sticky internal overflow flag, cleared on an accepted start.
REQ-022 In hex_mode, digit k SHALL equal nibble k of the raw value, with zero extension above WIDTH; neg and overflow SHALL be 0; hex digits beyond ceil(WIDTH/4) SHALL count as leading zeros.
REQ-023 LOAD SHALL, in one cycle, update bcd, neg, overflow and seg, pulse done=1, clear busy and return to IDLE.
REQ-024 Latency from the start cycle to done SHALL be WIDTH+1 cycles in decimal mode and 1 cycle in hex mode.
REQ-025 Result outputs SHALL hold their last loaded values during a conversion; there SHALL be no intermediate values on bcd or seg.
REQ-026 start SHALL be ignored while busy=1, including in the LOAD cycle; a start in the cycle after done SHALL be accepted.
REQ-027 Segment encoding SHALL be 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000, A:0001000, b:0000011, C:1000110, d:0100001, E:0000110, F:0001110.
REQ-028 When blank_lz=1, every zero digit above the most significant non-zero digit SHALL display 7'b1111111; digit 0 SHALL always be shown.
REQ-029 When overflow=1, every digit SHALL display 7'b0111111 (dash); bcd SHALL still hold the truncated low DIGITS digits.
REQ-030 Negative zero SHALL NOT be produced: an input of 0 SHALL give neg=0.

Reset
REQ-031 While rst=1, the block SHALL be held in IDLE with busy=0, done=0, bcd=0, neg=0 and overflow=0, seg all 7'b1111111 and neg_seg=7'b1111111.
REQ-032 Asserting rst mid-conversion SHALL abort it immediately with no done pulse; after release the block SHALL accept start.

Verification
REQ-033 Defaults, value=12345 decimal, blank_lz=0 -> done exactly 17 cycles after start, bcd=0x12345, neg=0, overflow=0, seg shows 1,2,3,4,5.
REQ-034 value=16'hFFFF, blank_lz=1 -> bcd=0x00001, neg=1, neg_seg=0111111, digits 4..1 blank and digit 0 =1111001; value=16'h8000 -> bcd=0x32768, neg=1.
REQ-035 DIGITS=4, value=12345 -> overflow=1, bcd=0x2345, all four digits show dash.
REQ-036 hex_mode=1, value=16'hBEEF -> done 1 cycle after start, bcd=0x0BEEF, neg=0, digit 4 blank when blank_lz=1.
REQ-037 A start pulsed during busy is ignored, so the outputs still reflect the first value; rst asserted 5 cycles into SHIFT -> all outputs go to reset values, no done pulse, and the next start converts correctly.
REQ-038 SIGNED=0, WIDTH=8, DIGITS=3, value=8'hFF -> bcd=0x255, neg=0, done 9 cycles after start.
